// File: rtl/cpu_sequencer.sv
// cpu_sequencer: owns the CPU FSM state register, gates datapath writes via adv, run/step/halt debug control.
// Optional performance counters are built only when SEQ_PERF_CNT_EN is defined.
module cpu_sequencer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       next_state,
   input  logic             cu_halt,
   input  logic             mem_ready,
   input  logic             run,
   input  logic             step,
   input  logic             resume,
   output logic [2:0]       state,
   output logic             adv,
   output logic             stopped,
   output logic             halted,
   output logic             instr_done,
   output logic             fault,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count
);
   typedef enum logic [2:0] {
      FETCH      = 3'b000,
      DECODE     = 3'b001,
      EXECUTE    = 3'b010,
      MEMORY     = 3'b011,
      WRITEBACK  = 3'b100,
      HALT_STATE = 3'b101
   } state_e;

   localparam int WW = $clog2(MEM_TIMEOUT + 1);

   state_e          state_q, state_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic            fault_q, fault_d;
   logic            done_q, done_d;
   logic            stall, timeout;

   assign adv = (state_q == FETCH)  ? (run | step) :
                (state_q == MEMORY) ? mem_ready :
                (state_q == DECODE || state_q == EXECUTE || state_q == WRITEBACK);
   assign stall   = (state_q == MEMORY) && !mem_ready;
   assign timeout = stall && (wait_q == WW'(MEM_TIMEOUT - 1));
   assign wait_d  = stall ? wait_q + 1'b1 : '0;

   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      if (state_q == HALT_STATE) begin
         if (resume) begin
            state_d = FETCH;
            fault_d = 1'b0;
         end
      end else if (state_q > HALT_STATE || timeout) begin
         state_d = HALT_STATE;
         fault_d = 1'b1;
      end else if (adv) begin
         if (next_state[2:1] == 2'b11) begin
            state_d = HALT_STATE;
            fault_d = 1'b1;
         end else if (cu_halt || next_state == HALT_STATE) begin
            state_d = HALT_STATE;
         end else begin
            state_d = state_e'(next_state);
         end
      end
      done_d = adv && state_q != FETCH && state_d == FETCH;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         wait_q  <= '0;
         fault_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         fault_q <= fault_d;
         done_q  <= done_d;
      end
   end

   assign state      = state_q;
   assign stopped    = (state_q == FETCH) && !run;
   assign halted     = (state_q == HALT_STATE);
   assign instr_done = done_q;
   assign fault      = fault_q;

`ifdef SEQ_PERF_CNT_EN
   logic [CNT_W-1:0] cyc_q, ins_q;
   logic             cnt_act;
   // a stepped FETCH cycle counts as active even though the sequencer is parked there
   assign cnt_act = (state_q != HALT_STATE) && (state_q != FETCH || run || step);

   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_q <= '0;
         ins_q <= '0;
      end else begin
         if (cnt_act && !(&cyc_q)) cyc_q <= cyc_q + 1'b1;
         if (done_d && !(&ins_q)) ins_q <= ins_q + 1'b1;
      end
   end

   assign cycle_count = cyc_q;
   assign instr_count = ins_q;
`else
   assign cycle_count = '0;
   assign instr_count = '0;
`endif
endmodule
